// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : fwd_hazard_unit
// Purpose  : Operand forwarding and load-use hazard detection for the EX stage
//            of a 5-stage pipeline. Tracks EX/MEM/WB destination tags, picks
//            the freshest value for each EX source operand, stalls decode for
//            one cycle on a load-use dependency and counts stall cycles.
// Revision : 1.0 - initial release
// ============================================================================
module fwd_hazard_unit #(
   parameter int WIDTH    = 32,
   parameter int REG_BITS = 4,
   parameter int NSRC     = 2,
   parameter int ZERO_REG = 1,
   parameter int CNT_W    = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     id_valid,
   input  logic [NSRC*REG_BITS-1:0] id_src,
   input  logic [NSRC-1:0]          id_src_used,
   input  logic [REG_BITS-1:0]      id_dst,
   input  logic                     id_we,
   input  logic                     id_is_load,
   input  logic                     flush,
   input  logic [NSRC*WIDTH-1:0]    ex_opnd_rf,
   input  logic [WIDTH-1:0]         mem_result,
   input  logic [WIDTH-1:0]         wb_result,
   input  logic                     stall_cnt_clr,
   output logic [NSRC*WIDTH-1:0]    ex_opnd,
   output logic                     stall,
   output logic                     fwd_err,
   output logic [CNT_W-1:0]         stall_cnt
);

   localparam logic [CNT_W-1:0]    CNT_MAX  = '1;
   localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
   localparam logic [REG_BITS-1:0] TAG_ZERO = '0;
   localparam bit                  ZERO_EN  = (ZERO_REG != 0);

   // ------------------------------------------------------------------------
   // Tag pipeline. EX keeps the full record (its sources drive forwarding);
   // MEM and WB only need the producer fields, since nothing downstream of EX
   // ever looks at their source tags.
   // ------------------------------------------------------------------------
   logic                     ex_valid_q, ex_valid_d;
   logic                     ex_we_q,    ex_we_d;
   logic                     ex_load_q,  ex_load_d;
   logic [REG_BITS-1:0]      ex_dst_q,   ex_dst_d;
   logic [NSRC*REG_BITS-1:0] ex_src_q,   ex_src_d;
   logic [NSRC-1:0]          ex_used_q,  ex_used_d;

   logic                     mem_valid_q, mem_valid_d;
   logic                     mem_we_q,    mem_we_d;
   logic                     mem_load_q,  mem_load_d;
   logic [REG_BITS-1:0]      mem_dst_q,   mem_dst_d;

   logic                     wb_valid_q, wb_valid_d;
   logic                     wb_we_q,    wb_we_d;
   logic [REG_BITS-1:0]      wb_dst_q,   wb_dst_d;

   logic [CNT_W-1:0]         stall_cnt_q, stall_cnt_d;

   logic                     ex_take;
   logic                     hazard;
   logic [NSRC-1:0]          src_mem_hit;
   logic [NSRC-1:0]          src_haz;

   // Decode enters EX only when it is real, not held, and not killed.
   assign ex_take = id_valid & ~stall & ~flush;

   // Next-state of the tag records: decode into EX (or a fully cleared
   // bubble), then EX shifts into MEM and MEM into WB unconditionally.
   always_comb begin
      ex_valid_d  = ex_take;
      ex_we_d     = ex_take & id_we;
      ex_load_d   = ex_take & id_is_load;
      ex_dst_d    = ex_take ? id_dst      : TAG_ZERO;
      ex_src_d    = ex_take ? id_src      : '0;
      ex_used_d   = ex_take ? id_src_used : '0;

      mem_valid_d = ex_valid_q;
      mem_we_d    = ex_we_q;
      mem_load_d  = ex_load_q;
      mem_dst_d   = ex_dst_q;

      wb_valid_d  = mem_valid_q;
      wb_we_d     = mem_we_q;
      wb_dst_d    = mem_dst_q;
   end

   // Tag registers; reset discards every in-flight instruction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid_q  <= 1'b0;
         ex_we_q     <= 1'b0;
         ex_load_q   <= 1'b0;
         ex_dst_q    <= TAG_ZERO;
         ex_src_q    <= '0;
         ex_used_q   <= '0;
         mem_valid_q <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_load_q  <= 1'b0;
         mem_dst_q   <= TAG_ZERO;
         wb_valid_q  <= 1'b0;
         wb_we_q     <= 1'b0;
         wb_dst_q    <= TAG_ZERO;
      end else begin
         ex_valid_q  <= ex_valid_d;
         ex_we_q     <= ex_we_d;
         ex_load_q   <= ex_load_d;
         ex_dst_q    <= ex_dst_d;
         ex_src_q    <= ex_src_d;
         ex_used_q   <= ex_used_d;
         mem_valid_q <= mem_valid_d;
         mem_we_q    <= mem_we_d;
         mem_load_q  <= mem_load_d;
         mem_dst_q   <= mem_dst_d;
         wb_valid_q  <= wb_valid_d;
         wb_we_q     <= wb_we_d;
         wb_dst_q    <= wb_dst_d;
      end
   end

   // ------------------------------------------------------------------------
   // Per-source forwarding (EX operands) and dependency detection (decode
   // sources against a load sitting in EX).
   // ------------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
         logic [REG_BITS-1:0] src_tag;
         logic                src_zero;
         logic                mem_hit;
         logic                wb_hit;
         logic [REG_BITS-1:0] id_tag;
         logic                id_zero;

         assign src_tag  = ex_src_q[gi*REG_BITS +: REG_BITS];
         assign src_zero = ZERO_EN && (src_tag == TAG_ZERO);

         // MEM holds the younger producer, so it is checked before WB.
         assign mem_hit  = ex_used_q[gi] & mem_valid_q & mem_we_q &
                           (mem_dst_q == src_tag) & ~src_zero;
         assign wb_hit   = ex_used_q[gi] & wb_valid_q & wb_we_q &
                           (wb_dst_q == src_tag) & ~src_zero;

         assign ex_opnd[gi*WIDTH +: WIDTH] =
            mem_hit ? mem_result :
            wb_hit  ? wb_result  :
                      ex_opnd_rf[gi*WIDTH +: WIDTH];

         assign src_mem_hit[gi] = mem_hit;

         assign id_tag   = id_src[gi*REG_BITS +: REG_BITS];
         assign id_zero  = ZERO_EN && (id_tag == TAG_ZERO);
         assign src_haz[gi] = id_src_used[gi] & (id_tag == ex_dst_q) & ~id_zero;
      end
   endgenerate

   // A load in MEM has no data yet; forwarding from it means a missed stall.
   assign fwd_err = mem_load_q & (|src_mem_hit);

   // Load-use: decode reads what the load in EX will write.
   assign hazard  = id_valid & ex_valid_q & ex_load_q & ex_we_q & (|src_haz);

   // A flushed consumer is dead, so there is nothing to wait for.
   assign stall   = hazard & ~flush;

   // ------------------------------------------------------------------------
   // Saturating stall-cycle counter; clear beats increment.
   // ------------------------------------------------------------------------
   // Next counter value.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_cnt_clr) begin
         stall_cnt_d = '0;
      end else if (stall && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fwd_hazard_unit
// Purpose  : Directed self-checking bench for fwd_hazard_unit (CNT_W=2 so the
//            counter saturation is reachable in a few stalls).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fwd_hazard_unit;

   localparam int WIDTH    = 32;
   localparam int REG_BITS = 4;
   localparam int NSRC     = 2;
   localparam int CNT_W    = 2;
   localparam logic [63:0] RF_DEF = {32'h0000_0101, 32'h0000_0100};

   logic                     clk;
   logic                     rst_n;
   logic                     id_valid;
   logic [NSRC*REG_BITS-1:0] id_src;
   logic [NSRC-1:0]          id_src_used;
   logic [REG_BITS-1:0]      id_dst;
   logic                     id_we;
   logic                     id_is_load;
   logic                     flush;
   logic [NSRC*WIDTH-1:0]    ex_opnd_rf;
   logic [WIDTH-1:0]         mem_result;
   logic [WIDTH-1:0]         wb_result;
   logic                     stall_cnt_clr;
   logic [NSRC*WIDTH-1:0]    ex_opnd;
   logic                     stall;
   logic                     fwd_err;
   logic [CNT_W-1:0]         stall_cnt;

   int n_checks = 0;
   int n_errors = 0;

   fwd_hazard_unit #(
      .WIDTH    (WIDTH),
      .REG_BITS (REG_BITS),
      .NSRC     (NSRC),
      .ZERO_REG (1),
      .CNT_W    (CNT_W)
   ) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .id_valid      (id_valid),
      .id_src        (id_src),
      .id_src_used   (id_src_used),
      .id_dst        (id_dst),
      .id_we         (id_we),
      .id_is_load    (id_is_load),
      .flush         (flush),
      .ex_opnd_rf    (ex_opnd_rf),
      .mem_result    (mem_result),
      .wb_result     (wb_result),
      .stall_cnt_clr (stall_cnt_clr),
      .ex_opnd       (ex_opnd),
      .stall         (stall),
      .fwd_err       (fwd_err),
      .stall_cnt     (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its expected value.
   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic set_id(input logic v, input logic [3:0] s0, input logic [3:0] s1,
                         input logic [1:0] used, input logic [3:0] dst,
                         input logic we, input logic ld);
      id_valid    = v;
      id_src      = {s1, s0};
      id_src_used = used;
      id_dst      = dst;
      id_we       = we;
      id_is_load  = ld;
   endtask

   task automatic idle();
      set_id(1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      idle();
      tick(); tick(); tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n         = 1'b0;
      flush         = 1'b0;
      stall_cnt_clr = 1'b0;
      ex_opnd_rf    = RF_DEF;
      mem_result    = 32'h0;
      wb_result     = 32'h0;
      idle();

      // ---------------- reset state ----------------
      #12;
      check_val("rst_stall",   {63'd0, stall},   64'd0);
      check_val("rst_cnt",     {62'd0, stall_cnt}, 64'd0);
      check_val("rst_fwd_err", {63'd0, fwd_err}, 64'd0);
      check_val("rst_opnd",    ex_opnd,          RF_DEF);
      rst_n = 1'b1;
      tick(); tick(); tick();
      check_val("idle_stall", {63'd0, stall},     64'd0);
      check_val("idle_cnt",   {62'd0, stall_cnt}, 64'd0);
      check_val("idle_opnd",  ex_opnd,            RF_DEF);

      // ---------------- MEM then WB forwarding ----------------
      set_id(1'b1, 4'd0, 4'd0, 2'b00, 4'd3, 1'b1, 1'b0); tick();   // A: r3 <- alu
      set_id(1'b1, 4'd3, 4'd0, 2'b01, 4'd4, 1'b1, 1'b0); tick();   // B reads r3
      set_id(1'b1, 4'd3, 4'd0, 2'b01, 4'd6, 1'b1, 1'b0);           // C reads r3
      mem_result = 32'h11; wb_result = 32'h22; #1;
      check_val("fwd_mem_s0",  {32'd0, ex_opnd[31:0]},  64'h11);
      check_val("fwd_mem_s1",  {32'd0, ex_opnd[63:32]}, 64'h101);
      check_val("fwd_nostall", {63'd0, stall},          64'd0);
      tick(); idle(); #1;
      check_val("fwd_wb_s0",   {32'd0, ex_opnd[31:0]},  64'h22);
      drain();

      // ---------------- MEM priority over WB ----------------
      set_id(1'b1, 4'd0, 4'd0, 2'b00, 4'd3, 1'b1, 1'b0); tick();
      set_id(1'b1, 4'd0, 4'd0, 2'b00, 4'd3, 1'b1, 1'b0); tick();
      set_id(1'b1, 4'd3, 4'd3, 2'b11, 4'd7, 1'b0, 1'b0); tick();
      idle();
      mem_result = 32'hAA; wb_result = 32'hBB; #1;
      check_val("prio_s0",  {32'd0, ex_opnd[31:0]},  64'hAA);
      check_val("prio_s1",  {32'd0, ex_opnd[63:32]}, 64'hAA);
      check_val("prio_err", {63'd0, fwd_err},        64'd0);
      drain();

      // ---------------- load-use stall ----------------
      set_id(1'b1, 4'd0, 4'd0, 2'b00, 4'd5, 1'b1, 1'b1); tick();   // load r5
      set_id(1'b1, 4'd0, 4'd5, 2'b10, 4'd8, 1'b1, 1'b0); #1;       // reads r5 (slot1)
      check_val("lu_stall",     {63'd0, stall},     64'd1);
      tick();
      check_val("lu_stall_end", {63'd0, stall},     64'd0);
      check_val("lu_cnt",       {62'd0, stall_cnt}, 64'd1);
      tick(); idle();
      mem_result = 32'hDEAD; wb_result = 32'h5A5A; #1;
      check_val("lu_wb_s1",     {32'd0, ex_opnd[63:32]}, 64'h5A5A);
      check_val("lu_unused_s0", {32'd0, ex_opnd[31:0]},  64'h100);
      drain();

      // flush wins over the stall
      set_id(1'b1, 4'd0, 4'd0, 2'b00, 4'd5, 1'b1, 1'b1); tick();
      set_id(1'b1, 4'd0, 4'd5, 2'b10, 4'd8, 1'b1, 1'b0);
      flush = 1'b1; #1;
      check_val("flush_stall", {63'd0, stall}, 64'd0);
      tick();
      flush = 1'b0; idle(); #1;
      check_val("flush_cnt", {62'd0, stall_cnt}, 64'd1);
      drain();

      // ---------------- hardwired r0 ----------------
      set_id(1'b1, 4'd0, 4'd0, 2'b00, 4'd0, 1'b1, 1'b1); tick();   // load r0
      set_id(1'b1, 4'd0, 4'd0, 2'b01, 4'd9, 1'b1, 1'b0); #1;       // reads r0
      check_val("r0_nostall", {63'd0, stall}, 64'd0);
      tick(); idle();
      ex_opnd_rf = {32'h0000_0101, 32'h0}; mem_result = 32'hFF; #1;
      check_val("r0_mem", {32'd0, ex_opnd[31:0]}, 64'h0);
      check_val("r0_err", {63'd0, fwd_err},       64'd0);
      drain();
      set_id(1'b1, 4'd0, 4'd0, 2'b00, 4'd0, 1'b1, 1'b0); tick();   // alu r0
      idle(); tick();
      set_id(1'b1, 4'd0, 4'd0, 2'b01, 4'd9, 1'b1, 1'b0); tick();
      idle();
      wb_result = 32'hFF; mem_result = 32'h77; #1;
      check_val("r0_wb", {32'd0, ex_opnd[31:0]}, 64'h0);
      ex_opnd_rf = RF_DEF;
      drain();

      // ---------------- back-to-back loads, counter saturation ----------------
      set_id(1'b1, 4'd0, 4'd0, 2'b00, 4'd1, 1'b1, 1'b1); tick();
      for (int k = 0; k < 5; k++) begin
         set_id(1'b1, 4'(k + 1), 4'd0, 2'b01, 4'(k + 2), 1'b1, 1'b1); #1;
         check_val("b2b_stall", {63'd0, stall}, 64'd1);
         tick();
         check_val("b2b_bubble", {63'd0, stall}, 64'd0);
         check_val("b2b_cnt", {62'd0, stall_cnt}, (k == 0) ? 64'd2 : 64'd3);
         tick();
      end
      drain();

      // stall and clear in the same cycle
      set_id(1'b1, 4'd0, 4'd0, 2'b00, 4'd5, 1'b1, 1'b1); tick();
      set_id(1'b1, 4'd5, 4'd0, 2'b01, 4'd8, 1'b1, 1'b0);
      stall_cnt_clr = 1'b1; #1;
      check_val("clr_stall", {63'd0, stall}, 64'd1);
      tick();
      stall_cnt_clr = 1'b0;
      check_val("clr_win_cnt", {62'd0, stall_cnt}, 64'd0);
      drain();

      // one more stall to make the counter non-zero
      set_id(1'b1, 4'd0, 4'd0, 2'b00, 4'd5, 1'b1, 1'b1); tick();
      set_id(1'b1, 4'd5, 4'd0, 2'b01, 4'd8, 1'b1, 1'b0); tick();
      check_val("cnt_one", {62'd0, stall_cnt}, 64'd1);
      drain();

      // ---------------- reset during a stall ----------------
      set_id(1'b1, 4'd0, 4'd0, 2'b00, 4'd7, 1'b1, 1'b1); tick();   // load r7
      set_id(1'b1, 4'd7, 4'd0, 2'b01, 4'd10, 1'b1, 1'b0); #1;
      check_val("rmid_stall_pre", {63'd0, stall}, 64'd1);
      rst_n = 1'b0; #1;
      check_val("rmid_stall",   {63'd0, stall},     64'd0);
      check_val("rmid_cnt",     {62'd0, stall_cnt}, 64'd0);
      rst_n = 1'b1;
      mem_result = 32'h1234;
      tick();
      idle(); #1;
      check_val("rpost_stall", {63'd0, stall},         64'd0);
      check_val("rpost_s0",    {32'd0, ex_opnd[31:0]}, 64'h100);
      drain();

      // ---------------- plain clear ----------------
      set_id(1'b1, 4'd0, 4'd0, 2'b00, 4'd5, 1'b1, 1'b1); tick();
      set_id(1'b1, 4'd5, 4'd0, 2'b01, 4'd8, 1'b1, 1'b0); tick();
      idle();
      check_val("pre_clr_cnt", {62'd0, stall_cnt}, 64'd1);
      stall_cnt_clr = 1'b1; tick();
      stall_cnt_clr = 1'b0;
      check_val("clr_cnt", {62'd0, stall_cnt}, 64'd0);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
